// File: rtl/led_pkg.sv
// Shared types and reset defaults for the multi-channel LED driver.
package led_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    LED_OFF     = 2'd0,
    LED_ON      = 2'd1,
    LED_BLINK   = 2'd2,
    LED_BREATHE = 2'd3
  } led_mode_t;

  // Out of reset every channel blinks at full brightness (legacy behaviour).
  localparam led_mode_t RST_MODE        = LED_BLINK;
  localparam logic      RST_BLINK_STATE = 1'b1;
  localparam logic      RST_DIR_UP      = 1'b1;

  // Width of a selector for n items, never less than one bit.
  function automatic int sel_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/led_channel.sv
// One LED channel: holds its configuration, runs the blink/breathe phase
// counter on shared ticks and registers the PWM-gated LED drive.
module led_channel
  import led_pkg::*;
#(
  parameter int PWM_BITS     = 8,
  parameter int PERIOD_BITS  = 16,
  parameter int RESET_PERIOD = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_tick,
  input  logic [PWM_BITS-1:0]    i_pwm_cnt,
  input  logic                   i_load,
  input  led_mode_t              i_mode,
  input  logic [PWM_BITS-1:0]    i_duty,
  input  logic [PERIOD_BITS-1:0] i_period,
  output logic                   o_led
);

  led_mode_t              r_mode;
  logic [PWM_BITS-1:0]    r_duty;
  logic [PERIOD_BITS-1:0] r_period;
  logic [PERIOD_BITS-1:0] r_phase;
  logic                   r_blink;
  logic [PWM_BITS-1:0]    r_level;
  logic                   r_dir_up;
  logic                   r_led;

  logic [PERIOD_BITS-1:0] w_last_phase;
  logic                   w_wrap;
  logic                   w_led_nxt;

  // Duty of all-ones means fully lit so the brightest setting has no dark slot.
  function automatic logic pwm_on(input logic [PWM_BITS-1:0] x,
                                  input logic [PWM_BITS-1:0] cnt);
    return (x == {PWM_BITS{1'b1}}) ? 1'b1 : (cnt < x);
  endfunction

  // A period of zero behaves like a period of one.
  assign w_last_phase = (r_period == '0) ? '0 : (r_period - PERIOD_BITS'(1));
  assign w_wrap       = i_tick && (r_phase >= w_last_phase);

  // Configuration and phase/blink/breathe state; a load overrides any tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mode   <= RST_MODE;
      r_duty   <= {PWM_BITS{1'b1}};
      r_period <= PERIOD_BITS'(RESET_PERIOD);
      r_phase  <= '0;
      r_blink  <= RST_BLINK_STATE;
      r_level  <= '0;
      r_dir_up <= RST_DIR_UP;
    end else if (i_load) begin
      r_mode   <= i_mode;
      r_duty   <= i_duty;
      r_period <= i_period;
      r_phase  <= '0;
      r_blink  <= RST_BLINK_STATE;
      r_level  <= '0;
      r_dir_up <= RST_DIR_UP;
    end else if (i_tick) begin
      r_phase <= w_wrap ? '0 : (r_phase + PERIOD_BITS'(1));
      if (w_wrap) begin
        case (r_mode)
          LED_BLINK: r_blink <= ~r_blink;
          LED_BREATHE: begin
            // Level ramps 0..duty and back, pausing one step at each end.
            if (r_dir_up) begin
              if (r_level < r_duty) r_level <= r_level + PWM_BITS'(1);
              else                  r_dir_up <= 1'b0;
            end else begin
              if (r_level > '0)     r_level <= r_level - PWM_BITS'(1);
              else                  r_dir_up <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Select the LED drive for the current mode.
  always_comb begin
    w_led_nxt = 1'b0;
    case (r_mode)
      LED_OFF:     w_led_nxt = 1'b0;
      LED_ON:      w_led_nxt = pwm_on(r_duty, i_pwm_cnt);
      LED_BLINK:   w_led_nxt = r_blink & pwm_on(r_duty, i_pwm_cnt);
      LED_BREATHE: w_led_nxt = pwm_on(r_level, i_pwm_cnt);
      default:     w_led_nxt = 1'b0;
    endcase
  end

  // Registered pin drive, one cycle behind the state it reflects.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_led <= 1'b0;
    else     r_led <= w_led_nxt;
  end

  assign o_led = r_led;

endmodule

// File: rtl/led_pwm_array.sv
// Multi-channel LED driver top: tick prescaler, shared PWM counter,
// configuration handshake and per-channel write decode.
module led_pwm_array
  import led_pkg::*;
#(
  parameter int NUM_CH       = 3,
  parameter int PWM_BITS     = 8,
  parameter int PERIOD_BITS  = 16,
  parameter int TICK_DIV     = 1000,
  parameter int RESET_PERIOD = 10,
  localparam int CH_W        = sel_width(NUM_CH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  input  logic [CH_W-1:0]        cfg_ch,
  input  logic [MODE_W-1:0]      cfg_mode,
  input  logic [PWM_BITS-1:0]    cfg_duty,
  input  logic [PERIOD_BITS-1:0] cfg_period,
  output logic [NUM_CH-1:0]      led
);

  localparam int                  PRESC_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRESC_W-1:0]  PRESC_MAX = PRESC_W'(TICK_DIV - 1);

  logic [PRESC_W-1:0]  r_presc;
  logic [PWM_BITS-1:0] r_pwm_cnt;
  logic                r_cfg_ready;

  logic                w_tick;
  logic                w_accept;
  logic [NUM_CH-1:0]   w_load;
  led_mode_t           w_mode;

  assign w_tick   = (r_presc == PRESC_MAX);
  assign w_accept = cfg_valid && r_cfg_ready;
  assign w_mode   = led_mode_t'(cfg_mode);

  // Prescaler producing a one-cycle tick every TICK_DIV clocks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         r_presc <= '0;
    else if (w_tick) r_presc <= '0;
    else             r_presc <= r_presc + PRESC_W'(1);
  end

  // Free-running PWM counter shared by all channels.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_pwm_cnt <= '0;
    else     r_pwm_cnt <= r_pwm_cnt + PWM_BITS'(1);
  end

  // Ready rises on the first edge out of reset and is never withdrawn.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_cfg_ready <= 1'b0;
    else     r_cfg_ready <= 1'b1;
  end

  assign cfg_ready = r_cfg_ready;

  // Out-of-range channel numbers match no channel, so such writes are dropped.
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign w_load[g] = w_accept && (cfg_ch == CH_W'(g));

    led_channel #(
      .PWM_BITS     (PWM_BITS),
      .PERIOD_BITS  (PERIOD_BITS),
      .RESET_PERIOD (RESET_PERIOD)
    ) u_channel (
      .clk       (clk),
      .rst       (rst),
      .i_tick    (w_tick),
      .i_pwm_cnt (r_pwm_cnt),
      .i_load    (w_load[g]),
      .i_mode    (w_mode),
      .i_duty    (cfg_duty),
      .i_period  (cfg_period),
      .o_led     (led[g])
    );
  end

endmodule

// File: tb/tb_led_pwm_array.sv
// Self-checking bench for led_pwm_array with an arithmetic reference model:
// each channel's expected output is derived from the number of ticks since
// its last load, not by stepping internal state.
module tb_led_pwm_array;

  localparam int NUM_CH  = 3;
  localparam int PWM_B   = 4;
  localparam int PER_B   = 16;
  localparam int TDIV    = 4;
  localparam int RST_PER = 2;
  localparam int PWM_MAX = (1 << PWM_B) - 1;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                cfg_valid = 1'b0;
  logic                cfg_ready;
  logic [1:0]          cfg_ch = '0;
  logic [1:0]          cfg_mode = '0;
  logic [PWM_B-1:0]    cfg_duty = '0;
  logic [PER_B-1:0]    cfg_period = '0;
  logic [NUM_CH-1:0]   led;

  led_pwm_array #(
    .NUM_CH       (NUM_CH),
    .PWM_BITS     (PWM_B),
    .PERIOD_BITS  (PER_B),
    .TICK_DIV     (TDIV),
    .RESET_PERIOD (RST_PER)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_ch     (cfg_ch),
    .cfg_mode   (cfg_mode),
    .cfg_duty   (cfg_duty),
    .cfg_period (cfg_period),
    .led        (led)
  );

  always #5 clk = ~clk;

  typedef struct {
    int mode;
    int duty;
    int period;
    int load_e;
  } chcfg_t;

  chcfg_t            mdl [NUM_CH];
  int                e;
  int                tests;
  int                fails;
  logic [NUM_CH-1:0] exp_led;

  function automatic logic pwm_on(input int x, input int cnt);
    return (x == PWM_MAX) ? 1'b1 : (cnt < x);
  endfunction

  // LED value after edge n: uses the state reached after n-1 edges and the
  // PWM count seen just before edge n. Ticks happen on edges that are
  // multiples of TDIV; a channel wraps once every max(period,1) ticks.
  function automatic logic exp_bit(input int ch, input int n);
    int m, cnt, k, p, w, r, d, lvl;
    m   = n - 1;
    cnt = m % (PWM_MAX + 1);
    d   = mdl[ch].duty;
    k   = m / TDIV - mdl[ch].load_e / TDIV;
    p   = (mdl[ch].period == 0) ? 1 : mdl[ch].period;
    w   = k / p;
    case (mdl[ch].mode)
      1: return pwm_on(d, cnt);
      2: return ((w % 2) == 0) && pwm_on(d, cnt);
      3: begin
        r   = w % (2 * d + 2);
        lvl = (r <= d) ? r : (2 * d + 1 - r);
        return pwm_on(lvl, cnt);
      end
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    e = 0;
    for (int i = 0; i < NUM_CH; i++) mdl[i] = '{2, PWM_MAX, RST_PER, 0};
  endtask

  // Drive one cycle of inputs, take the edge, compute expected led.
  task automatic cycle(input bit v, input int ch, input int mode,
                       input int duty, input int period);
    cfg_valid  = v;
    cfg_ch     = 2'(ch);
    cfg_mode   = 2'(mode);
    cfg_duty   = PWM_B'(duty);
    cfg_period = PER_B'(period);
    @(posedge clk);
    #1;
    e++;
    for (int i = 0; i < NUM_CH; i++) exp_led[i] = exp_bit(i, e);
    if (v && e >= 2 && ch < NUM_CH) mdl[ch] = '{mode, duty, period, e};
    cfg_valid = 1'b0;
  endtask

  task automatic test_reset();
    #21;
    tests++;
    if (led !== 3'b000) begin
      fails++; $display("FAIL reset_led: got %b want 000", led);
    end
    tests++;
    if (cfg_ready !== 1'b0) begin
      fails++; $display("FAIL reset_ready: got %b want 0", cfg_ready);
    end
    #1 rst = 1'b0;
    model_reset();
    cycle(0, 0, 0, 0, 0);
    tests++;
    if (cfg_ready !== 1'b1) begin
      fails++; $display("FAIL ready_after_release: got %b want 1", cfg_ready);
    end
    tests++;
    if (led !== exp_led) begin
      fails++; $display("FAIL reset_first_led: got %b want %b", led, exp_led);
    end
  endtask

  task automatic test_default_blink();
    for (int c = 0; c < 64; c++) begin
      cycle(0, 0, 0, 0, 0);
      tests++;
      if (led !== exp_led) begin
        fails++; $display("FAIL default_blink e=%0d: got %b want %b", e, led, exp_led);
      end
      tests++;
      if (led !== 3'b000 && led !== 3'b111) begin
        fails++; $display("FAIL blink_in_phase e=%0d: got %b want 000 or 111", e, led);
      end
    end
  endtask

  task automatic test_on_duty();
    int ones;
    cycle(1, 1, 1, 4, 3);
    for (int c = 0; c < 24; c++) begin
      cycle(0, 0, 0, 0, 0);
      tests++;
      if (led[1] !== exp_led[1]) begin
        fails++; $display("FAIL on_duty4 e=%0d: got %b want %b", e, led[1], exp_led[1]);
      end
    end
    ones = 0;
    for (int c = 0; c < 16; c++) begin
      cycle(0, 0, 0, 0, 0);
      ones += int'(led[1]);
    end
    tests++;
    if (ones != 4) begin
      fails++; $display("FAIL on_duty4_count: got %0d want 4", ones);
    end
    cycle(1, 1, 1, PWM_MAX, 3);
    cycle(0, 0, 0, 0, 0);
    for (int c = 0; c < 20; c++) begin
      cycle(0, 0, 0, 0, 0);
      tests++;
      if (led[1] !== 1'b1) begin
        fails++; $display("FAIL on_duty_full e=%0d: got %b want 1", e, led[1]);
      end
    end
    cycle(1, 1, 1, 0, 3);
    cycle(0, 0, 0, 0, 0);
    for (int c = 0; c < 20; c++) begin
      cycle(0, 0, 0, 0, 0);
      tests++;
      if (led[1] !== 1'b0) begin
        fails++; $display("FAIL on_duty_zero e=%0d: got %b want 0", e, led[1]);
      end
    end
  endtask

  task automatic test_breathe();
    cycle(1, 0, 3, 3, 1);
    for (int c = 0; c < 96; c++) begin
      cycle(0, 0, 0, 0, 0);
      tests++;
      if (led !== exp_led) begin
        fails++; $display("FAIL breathe e=%0d: got %b want %b", e, led, exp_led);
      end
    end
  endtask

  task automatic test_bad_channel();
    tests++;
    if (cfg_ready !== 1'b1) begin
      fails++; $display("FAIL bad_ch_ready: got %b want 1", cfg_ready);
    end
    cycle(1, 3, 0, 0, 0);
    for (int c = 0; c < 40; c++) begin
      cycle(0, 0, 0, 0, 0);
      tests++;
      if (led !== exp_led) begin
        fails++; $display("FAIL bad_channel e=%0d: got %b want %b", e, led, exp_led);
      end
    end
  endtask

  task automatic test_wrap_collision();
    int p2, guard, nx;
    bit hit;
    p2 = (mdl[2].period == 0) ? 1 : mdl[2].period;
    hit = 1'b0;
    guard = 0;
    while (!hit && guard < 200) begin
      nx = e + 1;
      if ((nx % TDIV == 0) && (((nx / TDIV - mdl[2].load_e / TDIV) % p2) == 0))
        hit = 1'b1;
      else
        cycle(0, 0, 0, 0, 0);
      guard++;
    end
    tests++;
    if (!hit) begin
      fails++; $display("FAIL wrap_align: got no wrap edge want one within 200 cycles");
    end
    cycle(1, 2, 2, 9, 3);
    for (int c = 0; c < 72; c++) begin
      cycle(0, 0, 0, 0, 0);
      tests++;
      if (led !== exp_led) begin
        fails++; $display("FAIL wrap_collision e=%0d: got %b want %b", e, led, exp_led);
      end
    end
  endtask

  task automatic test_async_reset();
    cycle(1, 0, 3, 3, 1);
    for (int c = 0; c < 30; c++) cycle(0, 0, 0, 0, 0);
    #2 rst = 1'b1;
    #1;
    tests++;
    if (led !== 3'b000) begin
      fails++; $display("FAIL async_rst_led: got %b want 000", led);
    end
    tests++;
    if (cfg_ready !== 1'b0) begin
      fails++; $display("FAIL async_rst_ready: got %b want 0", cfg_ready);
    end
    @(posedge clk);
    #3 rst = 1'b0;
    model_reset();
    cycle(0, 0, 0, 0, 0);
    tests++;
    if (cfg_ready !== 1'b1) begin
      fails++; $display("FAIL ready_after_async: got %b want 1", cfg_ready);
    end
    for (int c = 0; c < 64; c++) begin
      cycle(0, 0, 0, 0, 0);
      tests++;
      if (led !== exp_led) begin
        fails++; $display("FAIL post_reset_blink e=%0d: got %b want %b", e, led, exp_led);
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(7) == 0)
        cycle(1, $urandom_range(3), $urandom_range(3), $urandom_range(PWM_MAX),
              $urandom_range(4));
      else
        cycle(0, 0, 0, 0, 0);
      tests++;
      if (led !== exp_led) begin
        fails++; $display("FAIL random e=%0d: got %b want %b", e, led, exp_led);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tests = 0;
    fails = 0;
    model_reset();
    test_reset();
    test_default_blink();
    test_on_duty();
    test_breathe();
    test_bad_channel();
    test_wrap_collision();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
